// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial line, oversample strobe and FIFO read port of the UART receiver.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  logic                        rx;
  logic                        tick_os;
  logic                        rd_en;
  logic                        ovr_clr;
  logic [DATA_BITS-1:0]        rd_data;
  logic                        rd_perr;
  logic                        rd_ferr;
  logic                        empty;
  logic                        full;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic                        overrun;
  logic                        break_det;
  modport master (
    output rx, tick_os, rd_en, ovr_clr,
    input  rd_data, rd_perr, rd_ferr, empty, full, count, overrun, break_det
  );
  modport slave (
    input  rx, tick_os, rd_en, ovr_clr,
    output rd_data, rd_perr, rd_ferr, empty, full, count, overrun, break_det
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver feeding a first-word-fall-through FIFO of {perr,ferr,data}.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic pb, pb_n, fe, fe_n, done, done_n;
  logic perr, brk, push, pop, wr, full, empty, ovr;
  logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      pb    <= 1'b0;
      fe    <= 1'b0;
      done  <= 1'b0;
    end else begin
      rx_m  <= bus.rx;
      rx_s  <= rx_m;
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      pb    <= pb_n;
      fe    <= fe_n;
      done  <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    pb_n    = pb;
    fe_n    = fe;
    done_n  = 1'b0;
    if (bus.tick_os) begin
      cnt_n = cnt + 1'b1;
      case (state)
        S_IDLE: if (!rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
        S_START: if (cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          pb_n    = 1'b0;
          fe_n    = 1'b0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (cnt == LAST) begin
          sh_n  = {rx_s, sh[DATA_BITS-1:1]};
          idx_n = (idx == 4'(DATA_BITS - 1)) ? '0 : idx + 1'b1;
          if (idx == 4'(DATA_BITS - 1)) state_n = (PARITY != 0) ? S_PAR : S_STOP;
        end
        S_PAR: if (cnt == LAST) begin
          pb_n    = rx_s;
          state_n = S_STOP;
        end
        S_STOP: if (cnt == LAST) begin
          fe_n  = fe | ~rx_s;
          idx_n = idx + 1'b1;
          if (idx == 4'(STOP_BITS - 1)) begin
            done_n  = 1'b1;
            state_n = (fe | ~rx_s) ? S_WAIT : S_IDLE;
          end
        end
        S_WAIT: if (rx_s) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end
  // The frame stays in sh/pb/fe for the clk after the last stop sample, where it is pushed or flagged as a break.
  assign perr  = (PARITY != 0) && ((^sh ^ pb) != (PARITY == 1));
  assign brk   = done && fe && (sh == '0) && (PARITY == 0 || !pb);
  assign push  = done && !brk;
  assign full  = occ == (AW+1)'(FIFO_DEPTH);
  assign empty = occ == '0;
  assign pop   = bus.rd_en && !empty;
  assign wr    = push && (!full || pop);
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {perr, fe, sh};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
      ovr <= 1'b0;
    end else begin
      wp  <= wr ? wp + 1'b1 : wp;
      rp  <= pop ? rp + 1'b1 : rp;
      occ <= occ + (AW+1)'(wr) - (AW+1)'(pop);
      ovr <= (push && full && !pop) ? 1'b1 : (bus.ovr_clr ? 1'b0 : ovr);
    end
  end
  assign bus.rd_data   = empty ? '0 : mem[rp][DATA_BITS-1:0];
  assign bus.rd_ferr   = !empty && mem[rp][DATA_BITS];
  assign bus.rd_perr   = !empty && mem[rp][DATA_BITS+1];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = occ;
  assign bus.overrun   = ovr;
  assign bus.break_det = brk;
endmodule
